// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the fetch sequencer and its tick generator.
package fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/tick_gen.sv
// Step tick source: a free divider, or a synchronized pushbutton edge when SINGLE_STEP_EN is defined.
module tick_gen #(
    parameter int unsigned DIV_COUNT = 32'd50000000
) (
    input  logic Clk_O,
    input  logic Reset,
    input  logic Enable,
`ifdef SINGLE_STEP_EN
    input  logic Step_Btn,
`endif
    output logic Tick
);

`ifdef SINGLE_STEP_EN
    // Two flops tame the asynchronous button; the third remembers the previous level.
    logic [2:0] btn_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk_O or negedge Reset) begin
        if (!Reset) begin
            btn_sync <= 3'b000;
        end else begin
            btn_sync <= {btn_sync[1:0], Step_Btn};
        end
    end

    assign Tick = Enable && btn_sync[1] && !btn_sync[2];
`else
    localparam logic [31:0] LAST = 32'(DIV_COUNT - 32'd1);

    logic [31:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk_O or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (!Enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign Tick = Enable && (count == LAST);
`endif

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter / instruction register sequencer for the 8-bit MIPS datapath.
// Optional pushbutton stepping is enabled with the SINGLE_STEP_EN macro.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned     DIV_COUNT = 32'd50000000,
    parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic               Clk_O,
    input  logic               Reset,
    input  logic               Run,
`ifdef SINGLE_STEP_EN
    input  logic               Step_Btn,
`endif
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               Jump_En,
    input  logic [PC_W-1:0]    Jump_Address,
    output logic [PC_W-1:0]    PC,
    output logic [INSTR_W-1:0] IR,
    output logic               Exec_En,
    output logic               Halted
);

    state_e             state, state_next;
    logic [PC_W-1:0]    pc_next;
    logic [INSTR_W-1:0] ir_next;
    logic               tick;

    tick_gen #(
        .DIV_COUNT (DIV_COUNT)
    ) u_tick_gen (
        .Clk_O    (Clk_O),
        .Reset    (Reset),
        .Enable   (Run && (state == FETCH)),
`ifdef SINGLE_STEP_EN
        .Step_Btn (Step_Btn),
`endif
        .Tick     (tick)
    );

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = PC;
        ir_next    = IR;
        unique case (state)
            IDLE: begin
                if (Run) state_next = FETCH;
            end
            FETCH: begin
                if (tick) begin
                    ir_next    = Instruction;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // A jump to the current address is the program's halt idiom.
                if (Jump_En && (Jump_Address == PC)) begin
                    state_next = HALT;
                end else begin
                    pc_next    = Jump_En ? Jump_Address : PC + 8'd1;
                    state_next = FETCH;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk_O or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            PC      <= RESET_PC;
            IR      <= '0;
            Exec_En <= 1'b0;
        end else begin
            state   <= state_next;
            PC      <= pc_next;
            IR      <= ir_next;
            Exec_En <= (state_next == EXEC);
        end
    end

    assign Halted = (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a reference model predicts each Exec_En strobe
// (PC, IR, cycle) and a monitor compares them as the DUT presents strobes.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    localparam int unsigned DIV = 4;

    logic       Clk_O = 1'b0;
    logic       Reset = 1'b1;
    logic       Run = 1'b0;
    logic       Jump_En = 1'b0;
    logic [7:0] Jump_Address = 8'h00;
    logic [7:0] Instruction;
    logic [7:0] PC, IR;
    logic       Exec_En, Halted;
`ifdef SINGLE_STEP_EN
    logic       Step_Btn = 1'b0;
`endif

    logic [7:0] mem [256];
    assign Instruction = mem[PC];

    fetch_sequencer #(
        .DIV_COUNT (DIV),
        .RESET_PC  (8'h00)
    ) dut (
        .Clk_O        (Clk_O),
        .Reset        (Reset),
        .Run          (Run),
`ifdef SINGLE_STEP_EN
        .Step_Btn     (Step_Btn),
`endif
        .Instruction  (Instruction),
        .Jump_En      (Jump_En),
        .Jump_Address (Jump_Address),
        .PC           (PC),
        .IR           (IR),
        .Exec_En      (Exec_En),
        .Halted       (Halted)
    );

    always #5 Clk_O = ~Clk_O;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_strobes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] pc;
        logic [7:0] ir;
        int         cyc;
    } strobe_t;

    strobe_t exp_q[$];

    // Reference model: a step begins when Run has been high for DIV consecutive fetch cycles,
    // then one execute cycle moves the PC; a jump to itself stops everything.
    int         m_phase;   // 0 waiting for Run, 1 fetching, 2 executing, 3 halted
    int         m_run_cycles;
    logic [7:0] m_pc, m_ir;

`ifndef SINGLE_STEP_EN
    always @(posedge Clk_O or negedge Reset) begin
        if (!Reset) begin
            m_phase      = 0;
            m_run_cycles = 0;
            m_pc         = 8'h00;
            m_ir         = 8'h00;
        end else begin
            cyc++;
            case (m_phase)
                0: if (Run) m_phase = 1;
                1: begin
                    if (!Run) begin
                        m_run_cycles = 0;
                    end else begin
                        m_run_cycles++;
                        if (m_run_cycles == DIV) begin
                            m_run_cycles = 0;
                            m_ir         = mem[m_pc];
                            m_phase      = 2;
                            exp_q.push_back('{pc: m_pc, ir: m_ir, cyc: cyc});
                        end
                    end
                end
                2: begin
                    if (Jump_En && Jump_Address == m_pc) begin
                        m_phase = 3;
                    end else begin
                        m_pc    = Jump_En ? Jump_Address : m_pc + 8'd1;
                        m_phase = 1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    always @(posedge Clk_O) cyc++;
`endif

    always @(negedge Clk_O) begin
        strobe_t e;
        if (Reset && Exec_En) begin
            n_strobes++;
`ifndef SINGLE_STEP_EN
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: Exec_En=1 at PC=%0h cycle %0d, none expected", PC, cyc);
            end else begin
                e = exp_q.pop_front();
                check("strobe_pc", PC, e.pc);
                check("strobe_ir", IR, e.ir);
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_halted", Halted, 0);
            end
`endif
        end
    end

    task automatic wait_strobe(input string name);
        int n = 0;
        do begin
            @(negedge Clk_O);
            n++;
        end while (!Exec_En && n < 200);
        if (!Exec_En) begin
            checks++;
            errors++;
            $display("FAIL %s: no Exec_En within 200 cycles, got 0 expected 1", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int elapsed;
        foreach (mem[i]) mem[i] = 8'h15;
        #1 Reset = 1'b0;
        repeat (3) @(negedge Clk_O);
        check("reset_pc", PC, 8'h00);
        check("reset_ir", IR, 8'h00);
        check("reset_exec_en", Exec_En, 0);
        check("reset_halted", Halted, 0);
        Reset = 1'b1;

`ifdef SINGLE_STEP_EN
        @(negedge Clk_O);
        Run = 1'b1;
        repeat (5) @(negedge Clk_O);
        for (int p = 0; p < 3; p++) begin
            Step_Btn = 1'b1;
            repeat (10) @(negedge Clk_O);
            Step_Btn = 1'b0;
            repeat (10) @(negedge Clk_O);
        end
        repeat (20) @(negedge Clk_O);
        check("step_count", n_strobes, 3);
        check("step_pc", PC, 8'h03);
        check("step_halted", Halted, 0);
`else
        // Sequential stepping with a fixed instruction word.
        @(negedge Clk_O);
        Run = 1'b1;
        c0 = cyc;
        wait_strobe("t1_first");
        check("t1_latency", cyc - c0, DIV + 1);
        check("t1_ir", IR, 8'h15);
        check("t1_pc0", PC, 8'h00);
        c0 = cyc;
        wait_strobe("t1_second");
        check("t1_spacing", cyc - c0, DIV + 1);
        check("t1_pc1", PC, 8'h01);
        wait_strobe("t1_third");
        check("t1_pc2", PC, 8'h02);
        foreach (mem[i]) mem[i] = 8'($urandom);

        // Jump from 03 to 0A.
        @(negedge Clk_O);
        Jump_En = 1'b1;
        Jump_Address = 8'h0A;
        wait_strobe("t2_exec");
        check("t2_pc_before", PC, 8'h03);
        @(posedge Clk_O); #1;
        check("t2_pc_after", PC, 8'h0A);
        check("t2_halted", Halted, 0);
        Jump_En = 1'b0;
        wait_strobe("t2_next");
        check("t2_next_pc", PC, 8'h0A);
        check("t2_next_ir", IR, mem[8'h0A]);

        // Wrap from FF to 00.
        @(negedge Clk_O);
        Jump_En = 1'b1;
        Jump_Address = 8'hFF;
        wait_strobe("t4_jump");
        @(posedge Clk_O); #1;
        Jump_En = 1'b0;
        check("t4_pc_ff", PC, 8'hFF);
        wait_strobe("t4_exec_ff");
        @(posedge Clk_O); #1;
        check("t4_wrap_pc", PC, 8'h00);
        check("t4_halted", Halted, 0);

        // Pause mid-count, then resume.
        repeat (2) @(negedge Clk_O);
        Run = 1'b0;
        repeat (20) @(negedge Clk_O);
        check("t5_pause_pc", PC, 8'h00);
        check("t5_pause_ir", IR, mem[8'hFF]);
        check("t5_pause_exec_en", Exec_En, 0);
        Run = 1'b1;
        c0 = cyc;
        wait_strobe("t5_resume");
        elapsed = cyc - c0;
        check("t5_resume_window", (elapsed >= DIV && elapsed <= DIV + 1), 1);
        check("t5_resume_pc", PC, 8'h00);
        check("t5_resume_ir", IR, mem[8'h00]);

        // Randomized Run and jumps, never to the current PC.
        for (int k = 0; k < 400; k++) begin
            @(negedge Clk_O);
            Run          = ($urandom_range(0, 15) != 0);
            Jump_En      = ($urandom_range(0, 3) == 0);
            Jump_Address = m_pc + 8'($urandom_range(1, 255));
        end
        @(negedge Clk_O);
        Run = 1'b1;
        Jump_En = 1'b0;

        // Reset in the middle of an execute cycle.
        wait_strobe("t5_pre_reset");
        #2 Reset = 1'b0;
        #1;
        check("t5_reset_pc", PC, 8'h00);
        check("t5_reset_ir", IR, 8'h00);
        check("t5_reset_exec_en", Exec_En, 0);
        check("t5_reset_halted", Halted, 0);
        repeat (2) @(negedge Clk_O);
        check("t5_reset_no_pending", exp_q.size(), 0);
        Reset = 1'b1;

        // Jump-to-self halt at 07.
        wait_strobe("t3_first");
        @(negedge Clk_O);
        Jump_En = 1'b1;
        Jump_Address = 8'h07;
        wait_strobe("t3_to_07");
        @(posedge Clk_O); #1;
        check("t3_pc_07", PC, 8'h07);
        wait_strobe("t3_self_jump");
        @(posedge Clk_O); #1;
        check("t3_halted", Halted, 1);
        check("t3_pc_hold", PC, 8'h07);
        check("t3_exec_en_low", Exec_En, 0);
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk_O);
            Run          = 1'($urandom);
            Jump_En      = 1'($urandom);
            Jump_Address = 8'($urandom);
        end
        check("t3_still_halted", Halted, 1);
        check("t3_pc_final", PC, 8'h07);
        check("t3_ir_final", IR, mem[8'h07]);
        check("t3_no_pending", exp_q.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
